// File: rtl/change_dispenser.sv
// Change payout engine: breaks a requested amount into 5/2/1 coins greedily
// against a tracked inventory and issues them one at a time to a coin hopper.
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 8,
  parameter int INIT_CNT1   = 20,
  parameter int INIT_CNT2   = 20,
  parameter int INIT_CNT5   = 20,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             change_valid_i,
  input  logic [AMT_W-1:0] change_amount_i,
  output logic             change_ready_o,
  input  logic             refill_i,
  output logic             coin_req_o,
  output logic [2:0]       coin_sel_o,
  input  logic             coin_ack_i,
  output logic             done_o,
  output logic             short_o,
  output logic             fault_o,
  output logic [AMT_W-1:0] dispensed_total_o,
  output logic [CNT_W-1:0] cnt1_o,
  output logic [CNT_W-1:0] cnt2_o,
  output logic [CNT_W-1:0] cnt5_o
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_1    = 3'b001;
  localparam logic [2:0] SEL_2    = 3'b010;
  localparam logic [2:0] SEL_5    = 3'b100;

  localparam logic [CNT_W-1:0] INIT1    = CNT_W'(INIT_CNT1);
  localparam logic [CNT_W-1:0] INIT2    = CNT_W'(INIT_CNT2);
  localparam logic [CNT_W-1:0] INIT5    = CNT_W'(INIT_CNT5);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [AMT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d, cnt2_q, cnt2_d, cnt5_q, cnt5_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             ready_q, ready_d;
  logic             req_q, req_d;
  logic [2:0]       sel_q, sel_d;
  logic             done_q, done_d;
  logic             short_q, short_d;
  logic             fault_q, fault_d;
  logic [2:0]       pick_s;

  function automatic logic [AMT_W-1:0] coin_value(input logic [2:0] sel);
    logic [AMT_W-1:0] v;
    case (sel)
      SEL_5:   v = AMT_W'(3'd5);
      SEL_2:   v = AMT_W'(3'd2);
      SEL_1:   v = AMT_W'(3'd1);
      default: v = {AMT_W{1'b0}};
    endcase
    return v;
  endfunction

  // Largest coin that fits and is in stock; no backtracking on a dead end.
  function automatic logic [2:0] pick_coin(input logic [AMT_W-1:0] rem,
                                           input logic [CNT_W-1:0] c5,
                                           input logic [CNT_W-1:0] c2,
                                           input logic [CNT_W-1:0] c1);
    logic [2:0] sel;
    if (rem >= AMT_W'(3'd5) && c5 != {CNT_W{1'b0}}) begin
      sel = SEL_5;
    end else if (rem >= AMT_W'(3'd2) && c2 != {CNT_W{1'b0}}) begin
      sel = SEL_2;
    end else if (rem >= AMT_W'(3'd1) && c1 != {CNT_W{1'b0}}) begin
      sel = SEL_1;
    end else begin
      sel = SEL_NONE;
    end
    return sel;
  endfunction

  assign pick_s = pick_coin(rem_q, cnt5_q, cnt2_q, cnt1_q);

  // Next-state and next-output computation for the payout FSM.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    total_d = total_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    cnt5_d  = cnt5_q;
    tmr_d   = tmr_q;
    req_d   = req_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    short_d = short_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        // ready_q gates acceptance so the post-reset cycle cannot accept.
        if (ready_q && change_valid_i) begin
          rem_d   = change_amount_i;
          total_d = {AMT_W{1'b0}};
          short_d = 1'b0;
          state_d = S_SELECT;
        end else if (ready_q && refill_i) begin
          cnt1_d = INIT1;
          cnt2_d = INIT2;
          cnt5_d = INIT5;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SELECT: begin
        if (pick_s == SEL_NONE) begin
          short_d = (rem_q != {AMT_W{1'b0}});
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          req_d   = 1'b1;
          sel_d   = pick_s;
          tmr_d   = {TMR_W{1'b0}};
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (coin_ack_i) begin
          rem_d   = rem_q - coin_value(sel_q);
          total_d = total_q + coin_value(sel_q);
          case (sel_q)
            SEL_5:   cnt5_d = cnt5_q - CNT_W'(1'b1);
            SEL_2:   cnt2_d = cnt2_q - CNT_W'(1'b1);
            SEL_1:   cnt1_d = cnt1_q - CNT_W'(1'b1);
            default: cnt1_d = cnt1_q;
          endcase
          req_d   = 1'b0;
          sel_d   = SEL_NONE;
          state_d = S_SELECT;
        end else if (tmr_q == TMR_LAST) begin
          req_d   = 1'b0;
          sel_d   = SEL_NONE;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          tmr_d = tmr_q + TMR_W'(1'b1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: begin
        req_d   = 1'b0;
        sel_d   = SEL_NONE;
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rem_q   <= {AMT_W{1'b0}};
      total_q <= {AMT_W{1'b0}};
      cnt1_q  <= INIT1;
      cnt2_q  <= INIT2;
      cnt5_q  <= INIT5;
      tmr_q   <= {TMR_W{1'b0}};
      ready_q <= 1'b0;
      req_q   <= 1'b0;
      sel_q   <= SEL_NONE;
      done_q  <= 1'b0;
      short_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      total_q <= total_d;
      cnt1_q  <= cnt1_d;
      cnt2_q  <= cnt2_d;
      cnt5_q  <= cnt5_d;
      tmr_q   <= tmr_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
      short_q <= short_d;
      fault_q <= fault_d;
    end
  end

  assign change_ready_o    = ready_q;
  assign coin_req_o        = req_q;
  assign coin_sel_o        = sel_q;
  assign done_o            = done_q;
  assign short_o           = short_q;
  assign fault_o           = fault_q;
  assign dispensed_total_o = total_q;
  assign cnt1_o            = cnt1_q;
  assign cnt2_o            = cnt2_q;
  assign cnt5_o            = cnt5_q;

endmodule
